// File: rtl/data_memory_bytewise.sv
`default_nettype none
// ============================================================================
// Module  : data_memory_bytewise
// Brief   : MIPS MEM-stage data memory with byte/half/word access, alignment
//           checking and a valid/ready full-memory debug dump engine.
// Revision: 1.0 - initial release
// ============================================================================
module data_memory_bytewise #(
  parameter  int NB_DATA    = 32,
  parameter  int N_ELEMENTS = 128,
  localparam int NB_ADDR    = $clog2(N_ELEMENTS) + 2
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 enable_mem_i,
  input  logic [NB_ADDR-1:0]   addr_i,
  input  logic [NB_DATA-1:0]   data_write_i,
  input  logic                 mem_read_i,
  input  logic                 mem_write_i,
  input  logic [1:0]           size_i,
  input  logic                 unsigned_i,
  output logic [NB_DATA-1:0]   data_o,
  output logic                 misaligned_o,
  input  logic                 dump_start_i,
  input  logic                 dump_ready_i,
  output logic                 dump_valid_o,
  output logic [NB_DATA-1:0]   dump_data_o,
  output logic [NB_ADDR-3:0]   dump_addr_o,
  output logic                 dump_done_o,
  output logic                 busy_o
);

  localparam int              NB_IDX   = NB_ADDR - 2;
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_ELEMENTS - 1);
  localparam logic [1:0]      SIZE_BYTE = 2'b00;
  localparam logic [1:0]      SIZE_HALF = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } dump_state_t;

  dump_state_t state;
  dump_state_t state_next;

  logic [NB_IDX-1:0]  word_idx;
  logic [1:0]         byte_off;
  logic               misaligned;
  logic               access_en;
  logic               write_en;
  logic [3:0]         lane_en;
  logic [NB_DATA-1:0] lane_wdata;
  logic [NB_DATA-1:0] load_value;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [NB_IDX-1:0]  dump_idx;

  wire  [NB_DATA-1:0] rd_word;
  wire  [NB_DATA-1:0] dump_rd_word;

  assign word_idx = addr_i[NB_ADDR-1:2];
  assign byte_off = addr_i[1:0];

  always_comb begin
    misaligned = 1'b0;
    case (size_i)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = byte_off[0];
      default:   misaligned = |byte_off;
    endcase
  end

  // The dump engine owns the RAM while busy; pipeline requests are dropped.
  assign access_en = enable_mem_i & (mem_read_i | mem_write_i) & ~busy_o;
  assign write_en  = access_en & mem_write_i & ~misaligned;

  always_comb begin
    lane_en    = 4'b1111;
    lane_wdata = data_write_i;
    case (size_i)
      SIZE_BYTE: begin
        lane_en    = 4'b0001 << byte_off;
        lane_wdata = {4{data_write_i[7:0]}};
      end
      SIZE_HALF: begin
        lane_en    = byte_off[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{data_write_i[15:0]}};
      end
      default: begin
        lane_en    = 4'b1111;
        lane_wdata = data_write_i;
      end
    endcase
  end

  // One byte-wide array per lane so partial stores never touch other lanes.
  for (genvar lane = 0; lane < 4; lane++) begin : g_lane
    logic [7:0] ram [N_ELEMENTS];

    always_ff @(posedge clock_i) begin
      if (write_en && lane_en[lane]) begin
        ram[word_idx] <= lane_wdata[8*lane +: 8];
      end
    end

    assign rd_word[8*lane +: 8]      = ram[word_idx];
    assign dump_rd_word[8*lane +: 8] = ram[dump_idx];
  end

  assign byte_sel = rd_word[{byte_off, 3'b000} +: 8];
  assign half_sel = rd_word[{byte_off[1], 4'b0000} +: 16];

  always_comb begin
    load_value = rd_word;
    case (size_i)
      SIZE_BYTE: load_value = unsigned_i ? {{(NB_DATA-8){1'b0}}, byte_sel}
                                         : {{(NB_DATA-8){byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_value = unsigned_i ? {{(NB_DATA-16){1'b0}}, half_sel}
                                         : {{(NB_DATA-16){half_sel[15]}}, half_sel};
      default:   load_value = rd_word;
    endcase
  end

  // rd_word is sampled before the same-edge write lands, giving read-first.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      data_o       <= '0;
      misaligned_o <= 1'b0;
    end else if (access_en) begin
      if (misaligned) begin
        misaligned_o <= 1'b1;
      end else begin
        misaligned_o <= 1'b0;
        if (mem_read_i) begin
          data_o <= load_value;
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    busy_o       = 1'b1;
    dump_valid_o = 1'b0;
    dump_done_o  = 1'b0;
    case (state)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (dump_start_i) begin
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_next = ST_PRESENT;
      end
      ST_PRESENT: begin
        dump_valid_o = 1'b1;
        if (dump_ready_i) begin
          state_next = (dump_idx == LAST_IDX) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        dump_done_o = 1'b1;
        state_next  = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      dump_idx    <= '0;
      dump_data_o <= '0;
      dump_addr_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dump_start_i) begin
            dump_idx <= '0;
          end
        end
        ST_FETCH: begin
          dump_data_o <= dump_rd_word;
          dump_addr_o <= dump_idx;
        end
        ST_PRESENT: begin
          if (dump_ready_i && (dump_idx != LAST_IDX)) begin
            dump_idx <= dump_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/data_memory_bytewise.md
# data_memory_bytewise

Parametrised data memory for the MIPS MEM stage, replacing the word-only memory. It supports MIPS byte, halfword and word loads and stores (LB/LBU/LH/LHU/LW/SB/SH/SW) with little-endian byte lanes, sign or zero extension, and alignment checking. It also has a debug dump engine that streams the entire memory to the debug unit over a valid/ready handshake while the processor is halted.

## Interface
- NB_DATA, 32, data word width; fixed at 32 for MIPS size semantics
- N_ELEMENTS, 128, depth in words; power of two, ≥4
- NB_ADDR, clog2(N_ELEMENTS)+2, byte-address width (localparam); word index = addr_i[NB_ADDR-1:2]

Ports:
- clock_i  in  1  single clock, all logic on rising edge
- reset_n_i  in  1  synchronous, active-low reset
- enable_mem_i  in  1  pipeline access qualifier; low = no access, outputs hold
- addr_i  in  NB_ADDR  byte address
- data_write_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- mem_read_i  in  1  load request
- mem_write_i  in  1  store request
- size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- unsigned_i  in  1  1 = zero-extend loads, 0 = sign-extend
- data_o  out  32  registered, extended load result
- misaligned_o  out  1  registered, access aborted on alignment fault
- dump_start_i  in  1  start full-memory dump, sampled in IDLE only
- dump_ready_i  in  1  debug unit accepts dump word
- dump_valid_o  out  1  dump_data_o/dump_addr_o valid
- dump_data_o  out  32  dumped word
- dump_addr_o  out  NB_ADDR-2  word index of dumped word
- dump_done_o  out  1  one-cycle pulse after the last word is accepted
- busy_o  out  1  dump in progress

## Operation
- Reset (reset_n_i=0 at an edge): data_o=0, misaligned_o=0, dump_valid_o=0, dump_data_o=0, dump_addr_o=0, dump_done_o=0, busy_o=0, FSM→IDLE.
- RAM contents are not cleared by reset. Configuration-time content is all zeros.
- Alignment: half requires addr_i[0]=0. Word requires addr_i[1:0]=00. Byte is always aligned.
- Fault (enable_mem_i=1, read or write, misaligned): no RAM write, data_o holds, misaligned_o=1.
- Misaligned_o is cleared by the next enabled aligned access. It holds when enable_mem_i=0.
- Store: write only the lanes selected by size and offset.
  - Byte: lane addr_i[1:0] ← data_write_i[7:0].
  - Half: lanes {off+1,off} ← data_write_i[15:0].
  - Word: all four lanes.
  - Other lanes are unchanged.
- Load: read the word, select lane(s) by offset, then sign- or zero-extend to 32 bits. Word loads ignore unsigned_i.
- No read (mem_read_i=0, or enable low): data_o holds its previous value. It is never driven Z.
- Read and write to the same word in the same cycle: write commits, and the read returns the pre-write (old) data (read-first).
- While busy_o=1, pipeline accesses are ignored: no write, data_o and misaligned_o hold.
- Dump FSM states:
  - IDLE: on dump_start_i=1 → FETCH, idx=0, busy_o=1.
  - FETCH: dump_data_o←RAM[idx], dump_addr_o←idx → PRESENT.
  - PRESENT: dump_valid_o=1 held with stable data until dump_ready_i=1. On handshake: if idx=N_ELEMENTS-1 → DONE, else idx+1 → FETCH.
  - DONE: dump_done_o=1 for one cycle, dump_valid_o=0 → IDLE, busy_o=0.
- dump_start_i outside IDLE is ignored. Reset in any state aborts the dump at that edge.

## Timing
- Load latency: 1 cycle. Request sampled at edge k; data_o valid after edge k; the consumer samples at edge k+1.
- Stores commit at the sampling edge. A load of the same word at edge k+1 sees the new data.
- misaligned_o updates at the same edge as the faulting request.
- Dump throughput: 2 cycles/word with dump_ready_i held high.
- Dump total: 2·N_ELEMENTS cycles from the dump_start_i edge to entering DONE, plus 1 cycle for the done pulse.
- dump_valid_o drops the edge after handshake. Back-pressure stretches PRESENT indefinitely.

## Test plan
- Reset mid-dump: after 3 words, reset_n_i=0 for one edge → dump_valid_o=0, busy_o=0, IDLE. A fresh dump_start_i restarts at idx 0.
- SW 0x8081_7F01 @0x10; LB @0x10/0x11/0x12/0x13 → 0x0000_0001, 0x0000_007F, 0xFFFF_FF81, 0xFFFF_FF80. LBU @0x13 → 0x0000_0080.
- SH 0xBEEF @0x22 after SW 0 @0x20 → LW @0x20 = 0xBEEF_0000. LH @0x22 = 0xFFFF_BEEF. LHU @0x22 = 0x0000_BEEF.
- Misaligned: SW 0xFFFF_FFFF @0x21 → misaligned_o=1, LW @0x20 still 0xBEEF_0000 and misaligned_o=0. LH @0x23 → misaligned_o=1, data_o unchanged.
- Same-cycle read+write to word 0x30 (old 0x1111_1111, new 0x2222_2222) → data_o=0x1111_1111. Next LW → 0x2222_2222.
- Dump with N_ELEMENTS=8, word i = i·0x0101_0101, dump_ready_i low for 5 cycles on word 3:
  - Words 0..7 emitted in order with correct dump_addr_o.
  - Data holds stable during the stall.
  - One dump_done_o pulse.
  - A write attempted while busy_o=1 is not committed.
